clic_arbiter: RTL and testbench
===============================

CLIC_ARBITER -- requirements
Module: clic_arbiter

Interface
REQ-001 The module SHALL have one clock and one reset; reset is asynchronous and active-high.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 prio  input  PrioEntries  per-vector priority (N = 2**NR_INDEX_BITS entries).
REQ-005 enabled  input  BitEntries  per-vector enable.
REQ-006 pending  input  BitEntries  per-vector pending flag.
REQ-007 req_valid  output  1  interrupt request to core.
REQ-008 req_index  output  Index  vector of current request.
REQ-009 req_prio  output  Prio  priority of current request.
REQ-010 ack  input  1  core takes the request; sampled only while req_valid=1.
REQ-011 done  input  1  core finished the innermost handler (one-cycle pulse).
REQ-012 clear_valid  output  1  one-cycle pulse clearing pending of clear_index.
REQ-013 clear_index  output  Index  vector to clear.
REQ-014 cur_prio  output  Prio  current running priority threshold; 0 = thread level.

Function
REQ-015 The module SHALL implement states SCAN and REQ.
REQ-016 In SCAN, an index counter SHALL visit vector 0..N-1, one per cycle, then wrap to 0.
REQ-017 A visited vector SHALL be a candidate iff pending & enabled & prio != 0.
REQ-018 A candidate SHALL replace the running best only if its prio is strictly greater; ties resolve to the lower index.
REQ-019 At the cycle visiting N-1, if best exists and best_prio > cur_prio, the next state SHALL be REQ; otherwise the best is discarded and scanning restarts at 0.
REQ-020 Worst-case latency from pending assertion to req_valid SHALL be 2N cycles.
REQ-021 In REQ, req_valid=1 and req_index/req_prio SHALL be held stable until ack or withdrawal.
REQ-022 In REQ, if ack=1: push cur_prio onto the nesting stack, set cur_prio <= req_prio, pulse clear_valid with clear_index=req_index next cycle, return to SCAN at index 0.
REQ-023 In REQ, if ack=0 and the requested vector's pending or enabled is 0, the request SHALL be withdrawn (req_valid=0 next cycle) and scanning restarts at 0; ack=1 wins over withdrawal.
REQ-024 done=1 with non-empty stack SHALL pop: cur_prio <= top, depth-1; done with empty stack SHALL be ignored.
REQ-025 done and ack in the same cycle SHALL leave stack depth unchanged, top entry equal to the popped value, and cur_prio <= req_prio.
REQ-026 Stack depth SHALL be 2**NR_PRIO_BITS - 1 (pushes strictly increase cur_prio, so overflow is impossible).
REQ-027 A done pop lowering cur_prio SHALL be visible to the comparison in REQ-019 from the following cycle.
REQ-028 req_index/req_prio SHALL be 0 when req_valid=0; clear_index SHALL be 0 when clear_valid=0.

Reset
REQ-029 On reset: state SCAN, index 0, best cleared, stack empty, cur_prio 0, req_valid 0, clear_valid 0, all index/prio outputs 0.
REQ-030 Reset asserted mid-request or mid-nesting SHALL discard the request and stack without generating clear_valid.

Structure
REQ-031 N, Prio, Index, PrioEntries, BitEntries SHALL come from common_pkg; the state enum and stack depth constant SHALL be added to common_pkg.
REQ-032 The nesting stack SHALL be a sub-module clic_prio_stack (push, pop, top, empty).

Verification (NR_PRIO_BITS=3, NR_INDEX_BITS=2)
REQ-033 Vector 2 pending, enabled, prio 5 -> req_valid with index 2, prio 5 within 8 cycles; ack -> clear_valid index 2 next cycle, cur_prio 5.
REQ-034 Vectors 1 and 3 both prio 4 -> request index 1; vector 0 prio 0 pending never requested.
REQ-035 In handler at cur_prio 5: vector 3 prio 6 -> preempts (push 5, cur_prio 6); vector 0 prio 5 -> no request; done -> cur_prio 5; done -> cur_prio 0, vector 0 then requested.
REQ-036 Request on vector 2 pending, enabled dropped before ack -> req_valid falls next cycle, no clear_valid.
REQ-037 done and ack same cycle at depth 1 (cur_prio 3, top 0, req_prio 6) -> depth 1, top 0, cur_prio 6.
REQ-038 Reset asserted while req_valid=1 at depth 2 -> all outputs 0, stack empty, no clear pulse.

Source files
------------

// File: rtl/common_pkg.sv
// Shared widths, bus types and FSM encoding for the CLIC arbiter slice.
package common_pkg;

    localparam int unsigned NR_PRIO_BITS   = 3;
    localparam int unsigned NR_INDEX_BITS  = 2;
    localparam int unsigned N              = 2 ** NR_INDEX_BITS;
    localparam int unsigned STACK_DEPTH    = 2 ** NR_PRIO_BITS - 1;
    localparam int unsigned STACK_PTR_BITS = $clog2(STACK_DEPTH + 1);

    typedef logic [NR_PRIO_BITS-1:0]         Prio;
    typedef logic [NR_INDEX_BITS-1:0]        Index;
    typedef logic [N-1:0][NR_PRIO_BITS-1:0]  PrioEntries;
    typedef logic [N-1:0]                    BitEntries;

    typedef enum logic {
        SCAN = 1'b0,
        REQ  = 1'b1
    } state_e;

endpackage

// File: rtl/clic_prio_stack.sv
// LIFO of preempted priority levels; push and pop together replaces the top entry.
module clic_prio_stack
    import common_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    push,
    input  logic                    pop,
    input  logic [NR_PRIO_BITS-1:0] push_data,
    output logic [NR_PRIO_BITS-1:0] top,
    output logic                    empty
);

    logic [STACK_PTR_BITS-1:0] depth_q, depth_d;
    Prio                       mem_q [STACK_DEPTH];
    Prio                       mem_d [STACK_DEPTH];

    assign empty = (depth_q == '0);
    assign top   = empty ? '0 : mem_q[depth_q - STACK_PTR_BITS'(1)];

    always_comb begin
        depth_d = depth_q;
        mem_d   = mem_q;
        if (push && pop && !empty) begin
            mem_d[depth_q - STACK_PTR_BITS'(1)] = push_data;
        end else if (push) begin
            if (depth_q < STACK_PTR_BITS'(STACK_DEPTH)) begin
                mem_d[depth_q] = push_data;
                depth_d        = depth_q + STACK_PTR_BITS'(1);
            end
        end else if (pop && !empty) begin
            depth_d = depth_q - STACK_PTR_BITS'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            depth_q <= '0;
            for (int i = 0; i < int'(STACK_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            depth_q <= depth_d;
            mem_q   <= mem_d;
        end
    end

endmodule

// File: rtl/clic_arbiter.sv
// Round-robin scanning interrupt arbiter with priority-threshold nesting.
module clic_arbiter
    import common_pkg::*;
(
    input  logic                             clk,
    input  logic                             reset,
    input  logic [N-1:0][NR_PRIO_BITS-1:0]   prio,
    input  logic [N-1:0]                     enabled,
    input  logic [N-1:0]                     pending,
    output logic                             req_valid,
    output logic [NR_INDEX_BITS-1:0]         req_index,
    output logic [NR_PRIO_BITS-1:0]          req_prio,
    input  logic                             ack,
    input  logic                             done,
    output logic                             clear_valid,
    output logic [NR_INDEX_BITS-1:0]         clear_index,
    output logic [NR_PRIO_BITS-1:0]          cur_prio
);

    state_e state_q, state_d;
    Index   idx_q, idx_d;
    logic   best_valid_q, best_valid_d;
    Index   best_idx_q, best_idx_d;
    Prio    best_prio_q, best_prio_d;
    logic   req_valid_q, req_valid_d;
    Index   req_index_q, req_index_d;
    Prio    req_prio_q, req_prio_d;
    logic   clear_valid_q, clear_valid_d;
    Index   clear_index_q, clear_index_d;
    Prio    cur_prio_q, cur_prio_d;

    logic   cand;
    logic   sel_valid;
    Index   sel_idx;
    Prio    sel_prio;
    logic   push_c, pop_c;
    Prio    push_data_c;
    Prio    stack_top;
    logic   stack_empty;

    clic_prio_stack u_stack (
        .clk       (clk),
        .reset     (reset),
        .push      (push_c),
        .pop       (pop_c),
        .push_data (push_data_c),
        .top       (stack_top),
        .empty     (stack_empty)
    );

    // A simultaneous done re-pushes the popped level, so the stack top is preserved.
    assign pop_c       = done && !stack_empty;
    assign push_data_c = pop_c ? stack_top : cur_prio_q;

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        best_valid_d  = best_valid_q;
        best_idx_d    = best_idx_q;
        best_prio_d   = best_prio_q;
        req_valid_d   = req_valid_q;
        req_index_d   = req_index_q;
        req_prio_d    = req_prio_q;
        clear_valid_d = 1'b0;
        clear_index_d = '0;
        cur_prio_d    = cur_prio_q;
        push_c        = 1'b0;
        cand          = 1'b0;
        sel_valid     = best_valid_q;
        sel_idx       = best_idx_q;
        sel_prio      = best_prio_q;

        if (pop_c) begin
            cur_prio_d = stack_top;
        end

        case (state_q)
            SCAN: begin
                cand = pending[idx_q] && enabled[idx_q] && (prio[idx_q] != '0);
                if (cand && (!best_valid_q || (prio[idx_q] > best_prio_q))) begin
                    sel_valid = 1'b1;
                    sel_idx   = idx_q;
                    sel_prio  = prio[idx_q];
                end
                if (idx_q == Index'(N - 1)) begin
                    idx_d        = '0;
                    best_valid_d = 1'b0;
                    best_idx_d   = '0;
                    best_prio_d  = '0;
                    if (sel_valid && (sel_prio > cur_prio_q)) begin
                        state_d     = REQ;
                        req_valid_d = 1'b1;
                        req_index_d = sel_idx;
                        req_prio_d  = sel_prio;
                    end
                end else begin
                    idx_d        = idx_q + Index'(1);
                    best_valid_d = sel_valid;
                    best_idx_d   = sel_idx;
                    best_prio_d  = sel_prio;
                end
            end
            REQ: begin
                if (ack) begin
                    push_c        = 1'b1;
                    cur_prio_d    = req_prio_q;
                    clear_valid_d = 1'b1;
                    clear_index_d = req_index_q;
                    state_d       = SCAN;
                    idx_d         = '0;
                    req_valid_d   = 1'b0;
                    req_index_d   = '0;
                    req_prio_d    = '0;
                end else if (!(pending[req_index_q] && enabled[req_index_q])) begin
                    state_d     = SCAN;
                    idx_d       = '0;
                    req_valid_d = 1'b0;
                    req_index_d = '0;
                    req_prio_d  = '0;
                end
            end
            default: begin
                state_d = SCAN;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= SCAN;
            idx_q         <= '0;
            best_valid_q  <= 1'b0;
            best_idx_q    <= '0;
            best_prio_q   <= '0;
            req_valid_q   <= 1'b0;
            req_index_q   <= '0;
            req_prio_q    <= '0;
            clear_valid_q <= 1'b0;
            clear_index_q <= '0;
            cur_prio_q    <= '0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            best_valid_q  <= best_valid_d;
            best_idx_q    <= best_idx_d;
            best_prio_q   <= best_prio_d;
            req_valid_q   <= req_valid_d;
            req_index_q   <= req_index_d;
            req_prio_q    <= req_prio_d;
            clear_valid_q <= clear_valid_d;
            clear_index_q <= clear_index_d;
            cur_prio_q    <= cur_prio_d;
        end
    end

    assign req_valid   = req_valid_q;
    assign req_index   = req_index_q;
    assign req_prio    = req_prio_q;
    assign clear_valid = clear_valid_q;
    assign clear_index = clear_index_q;
    assign cur_prio    = cur_prio_q;

endmodule

// File: tb/tb_clic_arbiter.sv
// Directed bench for clic_arbiter: scan vectors table plus nesting/withdraw/reset sequences.
module tb_clic_arbiter;

    logic             clk;
    logic             reset;
    logic [3:0][2:0]  prio;
    logic [3:0]       enabled;
    logic [3:0]       pending;
    logic             req_valid;
    logic [1:0]       req_index;
    logic [2:0]       req_prio;
    logic             ack;
    logic             done;
    logic             clear_valid;
    logic [1:0]       clear_index;
    logic [2:0]       cur_prio;

    int checks = 0;
    int errors = 0;

    clic_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .prio        (prio),
        .enabled     (enabled),
        .pending     (pending),
        .req_valid   (req_valid),
        .req_index   (req_index),
        .req_prio    (req_prio),
        .ack         (ack),
        .done        (done),
        .clear_valid (clear_valid),
        .clear_index (clear_index),
        .cur_prio    (cur_prio)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] prio;
        logic [3:0]  en;
        logic [3:0]  pd;
        logic        exp_v;
        logic [1:0]  exp_i;
        logic [2:0]  exp_p;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        prio    = '0;
        enabled = '0;
        pending = '0;
        ack     = 1'b0;
        done    = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic set_vec(input int i, input int p, input logic en, input logic pd);
        prio[i]    = 3'(p);
        enabled[i] = en;
        pending[i] = pd;
    endtask

    task automatic wait_req(input int max, output logic got, output int cyc);
        got = 1'b0;
        cyc = 0;
        for (int c = 1; c <= max; c++) begin
            @(negedge clk);
            if (req_valid) begin
                got = 1'b1;
                cyc = c;
                break;
            end
        end
    endtask

    task automatic pulse_ack();
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
    endtask

    task automatic pulse_done();
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
    endtask

    logic got;
    int   cyc;
    logic seen;

    initial begin
        vecs[0] = '{{3'd0, 3'd5, 3'd0, 3'd0}, 4'b0100, 4'b0100, 1'b1, 2'd2, 3'd5};
        vecs[1] = '{{3'd4, 3'd0, 3'd4, 3'd0}, 4'b1011, 4'b1011, 1'b1, 2'd1, 3'd4};
        vecs[2] = '{{3'd0, 3'd0, 3'd0, 3'd0}, 4'b0001, 4'b0001, 1'b0, 2'd0, 3'd0};
        vecs[3] = '{{3'd7, 3'd7, 3'd7, 3'd7}, 4'b1111, 4'b1111, 1'b1, 2'd0, 3'd7};
        vecs[4] = '{{3'd6, 3'd2, 3'd7, 3'd0}, 4'b0110, 4'b1100, 1'b1, 2'd2, 3'd2};
        vecs[5] = '{{3'd7, 3'd0, 3'd0, 3'd1}, 4'b1001, 4'b1001, 1'b1, 2'd3, 3'd7};
        vecs[6] = '{{3'd3, 3'd3, 3'd3, 3'd3}, 4'b1111, 4'b0000, 1'b0, 2'd0, 3'd0};

        reset = 1'b1;
        ack   = 1'b0;
        done  = 1'b0;

        // Single-scan arbitration vectors
        for (int v = 0; v < 7; v++) begin
            do_reset();
            chk($sformatf("v%0d_rst_req_valid", v), int'(req_valid), 0);
            chk($sformatf("v%0d_rst_cur_prio", v), int'(cur_prio), 0);
            chk($sformatf("v%0d_rst_clear_valid", v), int'(clear_valid), 0);
            prio    = vecs[v].prio;
            enabled = vecs[v].en;
            pending = vecs[v].pd;
            wait_req(12, got, cyc);
            chk($sformatf("v%0d_valid", v), int'(got), int'(vecs[v].exp_v));
            if (vecs[v].exp_v) begin
                chk($sformatf("v%0d_index", v), int'(req_index), int'(vecs[v].exp_i));
                chk($sformatf("v%0d_prio", v), int'(req_prio), int'(vecs[v].exp_p));
                chk($sformatf("v%0d_latency_le8", v), int'(cyc <= 8), 1);
            end else begin
                chk($sformatf("v%0d_idle_index", v), int'(req_index), 0);
                chk($sformatf("v%0d_idle_prio", v), int'(req_prio), 0);
            end
        end

        // Take a request, then nest, preempt and unwind
        do_reset();
        set_vec(2, 5, 1'b1, 1'b1);
        wait_req(8, got, cyc);
        chk("a_valid", int'(got), 1);
        chk("a_index", int'(req_index), 2);
        chk("a_prio", int'(req_prio), 5);
        pulse_ack();
        pending[2] = 1'b0;
        chk("a_clear_valid", int'(clear_valid), 1);
        chk("a_clear_index", int'(clear_index), 2);
        chk("a_cur_prio", int'(cur_prio), 5);
        chk("a_req_dropped", int'(req_valid), 0);
        chk("a_depth", int'(dut.u_stack.depth_q), 1);
        @(negedge clk);
        chk("a_clear_pulse_end", int'(clear_valid), 0);
        chk("a_clear_index_zero", int'(clear_index), 0);

        set_vec(3, 6, 1'b1, 1'b1);
        set_vec(0, 5, 1'b1, 1'b1);
        wait_req(8, got, cyc);
        chk("b_preempt_valid", int'(got), 1);
        chk("b_preempt_index", int'(req_index), 3);
        chk("b_preempt_prio", int'(req_prio), 6);
        pulse_ack();
        pending[3] = 1'b0;
        chk("b_cur_prio6", int'(cur_prio), 6);
        chk("b_depth2", int'(dut.u_stack.depth_q), 2);
        chk("b_top5", int'(dut.u_stack.top), 5);
        wait_req(12, got, cyc);
        chk("b_no_req_at6", int'(got), 0);
        pulse_done();
        chk("b_pop_cur5", int'(cur_prio), 5);
        wait_req(12, got, cyc);
        chk("b_no_req_equal_prio", int'(got), 0);
        pulse_done();
        chk("b_pop_cur0", int'(cur_prio), 0);
        chk("b_depth0", int'(dut.u_stack.depth_q), 0);
        pulse_done();
        chk("b_empty_done_cur", int'(cur_prio), 0);
        chk("b_empty_done_depth", int'(dut.u_stack.depth_q), 0);
        wait_req(8, got, cyc);
        chk("b_v0_valid", int'(got), 1);
        chk("b_v0_index", int'(req_index), 0);
        chk("b_v0_prio", int'(req_prio), 5);

        // Withdrawal by dropping enable before ack
        do_reset();
        set_vec(2, 5, 1'b1, 1'b1);
        wait_req(8, got, cyc);
        chk("c_valid", int'(got), 1);
        enabled[2] = 1'b0;
        @(negedge clk);
        chk("c_withdrawn", int'(req_valid), 0);
        chk("c_index_zero", int'(req_index), 0);
        chk("c_prio_zero", int'(req_prio), 0);
        seen = clear_valid;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            seen = seen | clear_valid | req_valid;
        end
        chk("c_no_clear_no_req", int'(seen), 0);
        chk("c_cur_prio", int'(cur_prio), 0);

        // done and ack in the same cycle at depth 1
        do_reset();
        set_vec(1, 3, 1'b1, 1'b1);
        wait_req(8, got, cyc);
        chk("d_first_valid", int'(got), 1);
        pulse_ack();
        pending[1] = 1'b0;
        chk("d_cur3", int'(cur_prio), 3);
        set_vec(2, 6, 1'b1, 1'b1);
        wait_req(8, got, cyc);
        chk("d_second_valid", int'(got), 1);
        chk("d_second_prio", int'(req_prio), 6);
        ack  = 1'b1;
        done = 1'b1;
        @(negedge clk);
        ack  = 1'b0;
        done = 1'b0;
        pending[2] = 1'b0;
        chk("d_depth1", int'(dut.u_stack.depth_q), 1);
        chk("d_top0", int'(dut.u_stack.top), 0);
        chk("d_cur6", int'(cur_prio), 6);
        chk("d_clear_index", int'(clear_index), 2);
        pulse_done();
        chk("d_unwind_cur0", int'(cur_prio), 0);

        // Reset during a live request at depth 2
        do_reset();
        set_vec(1, 3, 1'b1, 1'b1);
        wait_req(8, got, cyc);
        pulse_ack();
        pending[1] = 1'b0;
        set_vec(2, 6, 1'b1, 1'b1);
        wait_req(8, got, cyc);
        pulse_ack();
        pending[2] = 1'b0;
        chk("e_depth2", int'(dut.u_stack.depth_q), 2);
        set_vec(3, 7, 1'b1, 1'b1);
        wait_req(8, got, cyc);
        chk("e_req_live", int'(got), 1);
        reset = 1'b1;
        #1;
        chk("e_rst_req_valid", int'(req_valid), 0);
        chk("e_rst_req_index", int'(req_index), 0);
        chk("e_rst_req_prio", int'(req_prio), 0);
        chk("e_rst_clear_valid", int'(clear_valid), 0);
        chk("e_rst_clear_index", int'(clear_index), 0);
        chk("e_rst_cur_prio", int'(cur_prio), 0);
        chk("e_rst_depth", int'(dut.u_stack.depth_q), 0);
        pending = '0;
        @(negedge clk);
        reset = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            seen = seen | clear_valid;
        end
        chk("e_no_clear_after_rst", int'(seen), 0);
        chk("e_cur_after_rst", int'(cur_prio), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
